// File: rtl/output_port_arbiter.sv
// output_port_arbiter
// Round-robin arbiter sharing one router output port among N_PORTS input
// buffers. Pops at most one flit per cycle from the winning buffer, registers
// it onto the output link and tracks downstream space with a credit counter.
//
// Optional build macro: OUTPUT_ARB_PACKET_LOCK_EN
//   When defined, a grant whose flit has the tail bit (DATA_WIDTH-1) clear
//   locks the output to that port until its tail flit goes out (wormhole).
//   When undefined, arbitration is per flit and the tail bit is ignored.
//
// lock state (macro builds only)
//   state    | meaning
//   lock_q=0 | free: any requester may win, search starts at rr_ptr_q
//   lock_q=1 | packet open: only lock_port_q may issue until its tail flit

module output_port_arbiter #(
    parameter int N_PORTS    = 5,
    parameter int DATA_WIDTH = 16,
    parameter int CREDITS    = 5,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PORTS-1:0]            buf_empty_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0] buf_data_i,
    output logic [N_PORTS-1:0]            buf_read_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic                          out_valid_o,
    input  logic                          credit_i,
    output logic [CNT_WIDTH-1:0]          credit_cnt_o,
    output logic [N_PORTS-1:0]            grant_o,
    output logic                          credit_err_o
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]  credit_cnt_q, credit_cnt_d;
    logic                  credit_err_q, credit_err_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [N_PORTS-1:0]    grant_q, grant_d;

    logic [N_PORTS-1:0]    req;
    logic [N_PORTS-1:0]    req_eff;
    logic [DATA_WIDTH-1:0] data_arr [N_PORTS];
    logic                  win_found;
    logic [PTR_W-1:0]      win_idx;
    logic [DATA_WIDTH-1:0] win_data;
    logic [N_PORTS-1:0]    win_onehot;
    logic                  issue;

    assign req = ~buf_empty_i;

`ifdef OUTPUT_ARB_PACKET_LOCK_EN
    logic             lock_q, lock_d;
    logic [PTR_W-1:0] lock_port_q, lock_port_d;

    // While a packet is open, mask every request except the locked port.
    always_comb begin
        req_eff = req;
        if (lock_q) begin
            req_eff = req & (N_PORTS'(1) << lock_port_q);
        end
    end
`else
    assign req_eff = req;
`endif

    // Unpack the flat head-flit bus into one entry per port.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            data_arr[p] = buf_data_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Rotating priority search: first requester at or after rr_ptr_q wins.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_PORTS)) begin
                sum = sum - (PTR_W+1)'(N_PORTS);
            end
            idx = sum[PTR_W-1:0];
            if (!win_found && req_eff[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign win_data   = data_arr[win_idx];
    assign win_onehot = N_PORTS'(1) << win_idx;

    // The pop strobe is held off during reset so buffers are never drained then.
    assign issue      = reset & win_found & (credit_cnt_q != '0);
    assign buf_read_o = issue ? win_onehot : '0;

    // Next-state for the output link, pointer and credit bookkeeping.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        out_data_d   = out_data_q;
        grant_d      = grant_q;
        out_valid_d  = issue;
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;

        if (issue) begin
            out_data_d = win_data;
            grant_d    = win_onehot;
            // While locked the winner is always lock_port, so this also
            // yields lock_port+1 when the tail flit closes the packet.
            rr_ptr_d   = (win_idx == PTR_W'(N_PORTS-1)) ? '0 : win_idx + 1'b1;
        end

        case ({issue, credit_i})
            2'b10: credit_cnt_d = credit_cnt_q - 1'b1;
            2'b01: begin
                if (credit_cnt_q == CNT_WIDTH'(CREDITS)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_cnt_d = credit_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef OUTPUT_ARB_PACKET_LOCK_EN
    // A non-tail flit opens (or keeps open) the packet; a tail flit closes it.
    always_comb begin
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        if (issue) begin
            if (!win_data[DATA_WIDTH-1]) begin
                lock_d      = 1'b1;
                lock_port_d = win_idx;
            end else begin
                lock_d = 1'b0;
            end
        end
    end

    // Packet lock registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q      <= 1'b0;
            lock_port_q <= '0;
        end else begin
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
        end
    end
`endif

    // Arbiter state and registered output link.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q     <= '0;
            credit_cnt_q <= CNT_WIDTH'(CREDITS);
            credit_err_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            grant_q      <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            grant_q      <= grant_d;
        end
    end

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign grant_o      = grant_q;
    assign credit_cnt_o = credit_cnt_q;
    assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: table of per-cycle vectors (requests, credit,
// expected pop strobe, credit count, error flag) plus hand sequences for the
// mid-stream reset and the packet-lock interleaving. Popped flits are queued
// with their due cycle and compared when the registered link presents them.
`timescale 1ns/1ps
module tb_output_port_arbiter;
    localparam int N  = 5;
    localparam int DW = 16;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    buf_empty;
    logic [N*DW-1:0] buf_data;
    logic [N-1:0]    buf_read;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            credit;
    logic [CW-1:0]   credit_cnt;
    logic [N-1:0]    grant;
    logic            credit_err;

    always #5 clk = ~clk;

    output_port_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .CREDITS(5), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .buf_empty_i  (buf_empty),
        .buf_data_i   (buf_data),
        .buf_read_o   (buf_read),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .credit_i     (credit),
        .credit_cnt_o (credit_cnt),
        .grant_o      (grant),
        .credit_err_o (credit_err)
    );

    int checks = 0;
    int errs   = 0;
    int cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [N-1:0]  grant;
        int            due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [N-1:0]  empty;
        logic          cr;
        logic [N-1:0]  rd;
        logic [CW-1:0] cnt;
        logic          err;
    } vec_t;
    vec_t tbl[$];

    logic [DW-1:0] last_data;
    logic [N-1:0]  last_grant;
    exp_t          mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [N*DW-1:0] rnd_data();
        logic [N*DW-1:0] r;
        for (int p = 0; p < N; p++) r[p*DW +: DW] = {1'b1, 15'($urandom)};
        return r;
    endfunction

    function automatic void add(input logic [N-1:0] e, input logic c, input logic [N-1:0] r,
                                input logic [CW-1:0] n, input logic x);
        tbl.push_back('{e, c, r, n, x});
    endfunction

    // Link monitor: registered flit must appear exactly one cycle after its pop.
    always @(negedge clk) begin
        if (!reset) begin
            last_data  = '0;
            last_grant = '0;
        end else begin
            chk("rd_onehot", 32'($onehot0(buf_read)), 32'd1);
            chk("rd_while_empty", 32'(buf_read & buf_empty), 32'd0);
            if (sb.size() > 0 && sb[0].due == cyc_n) begin
                mon_e = sb.pop_front();
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("out_data", 32'(out_data), 32'(mon_e.data));
                chk("grant", 32'(grant), 32'(mon_e.grant));
                last_data  = mon_e.data;
                last_grant = mon_e.grant;
            end else begin
                chk("out_valid_idle", 32'(out_valid), 32'd0);
                chk("out_data_hold", 32'(out_data), 32'(last_data));
                chk("grant_hold", 32'(grant), 32'(last_grant));
            end
        end
    end

    task automatic cyc(input logic [N-1:0] empty, input logic cr, input logic [N*DW-1:0] data,
                       input logic [N-1:0] exp_rd, input logic [CW-1:0] exp_cnt,
                       input logic exp_err, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        buf_empty = empty;
        credit    = cr;
        buf_data  = data;
        @(negedge clk);
        chk({tag, "/buf_read"}, 32'(buf_read), 32'(exp_rd));
        chk({tag, "/credit_cnt"}, 32'(credit_cnt), 32'(exp_cnt));
        chk({tag, "/credit_err"}, 32'(credit_err), 32'(exp_err));
        if (exp_rd != '0) begin
            e.data  = '0;
            e.grant = exp_rd;
            e.due   = cyc_n + 1;
            for (int p = 0; p < N; p++) if (exp_rd[p]) e.data = data[p*DW +: DW];
            sb.push_back(e);
        end
    endtask

    logic [N-1:0]    lk_exp [4];
    logic [N*DW-1:0] d;
    int              p2;

    initial begin
        // Round-robin with two requesters, credit returned every cycle.
        add(5'b10101, 1, 5'b00010, 5, 0);
        add(5'b10101, 1, 5'b01000, 5, 0);
        add(5'b10101, 1, 5'b00010, 5, 0);
        add(5'b10101, 1, 5'b01000, 5, 0);
        // Port 0 alone drains all credits, then waits; one credit -> one pop.
        add(5'b11110, 0, 5'b00001, 5, 0);
        add(5'b11110, 0, 5'b00001, 4, 0);
        add(5'b11110, 0, 5'b00001, 3, 0);
        add(5'b11110, 0, 5'b00001, 2, 0);
        add(5'b11110, 0, 5'b00001, 1, 0);
        add(5'b11110, 0, 5'b00000, 0, 0);
        add(5'b11110, 0, 5'b00000, 0, 0);
        add(5'b11110, 1, 5'b00000, 0, 0);
        add(5'b11110, 0, 5'b00001, 1, 0);
        add(5'b11110, 0, 5'b00000, 0, 0);
        // Refill to 2, simultaneous issue+credit, refill to 5, overflow.
        add(5'b11111, 1, 5'b00000, 0, 0);
        add(5'b11111, 1, 5'b00000, 1, 0);
        add(5'b11110, 1, 5'b00001, 2, 0);
        add(5'b11111, 0, 5'b00000, 2, 0);
        add(5'b11111, 1, 5'b00000, 2, 0);
        add(5'b11111, 1, 5'b00000, 3, 0);
        add(5'b11111, 1, 5'b00000, 4, 0);
        add(5'b11111, 1, 5'b00000, 5, 0);
        add(5'b11111, 0, 5'b00000, 5, 1);
        add(5'b11111, 1, 5'b00000, 5, 1);
        add(5'b11111, 0, 5'b00000, 5, 1);
        // Ports 0 and 4: pointer at 1 picks 4, then wraps to 0.
        add(5'b01110, 0, 5'b10000, 5, 1);
        add(5'b01110, 0, 5'b00001, 4, 1);
        add(5'b01110, 0, 5'b10000, 3, 1);

        reset     = 1'b0;
        buf_empty = '0;
        credit    = 1'b0;
        buf_data  = rnd_data();
        #12;
        chk("rst/buf_read", 32'(buf_read), 32'd0);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_data", 32'(out_data), 32'd0);
        chk("rst/grant", 32'(grant), 32'd0);
        chk("rst/credit_cnt", 32'(credit_cnt), 32'd5);
        chk("rst/credit_err", 32'(credit_err), 32'd0);
        buf_empty = '1;
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 10; i++) cyc('1, 0, rnd_data(), '0, 5, 0, "idle");

        foreach (tbl[i]) cyc(tbl[i].empty, tbl[i].cr, rnd_data(), tbl[i].rd, tbl[i].cnt, tbl[i].err, "tbl");

        // Reset while the last port-4 flit is on the link.
        @(posedge clk);
        #2;
        chk("midrst/pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst/out_valid", 32'(out_valid), 32'd0);
        chk("midrst/credit_cnt", 32'(credit_cnt), 32'd5);
        chk("midrst/grant", 32'(grant), 32'd0);
        chk("midrst/out_data", 32'(out_data), 32'd0);
        chk("midrst/credit_err", 32'(credit_err), 32'd0);
        chk("midrst/buf_read", 32'(buf_read), 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        buf_empty = '1;
        reset     = 1'b1;

        // Packet sequence: move pointer to 2, then port 2 (tails 0,0,1) vs port 0.
        cyc(5'b11101, 1, rnd_data(), 5'b00010, 5, 0, "pkt_pre");
`ifdef OUTPUT_ARB_PACKET_LOCK_EN
        lk_exp = '{5'b00100, 5'b00100, 5'b00100, 5'b00001};
`else
        lk_exp = '{5'b00100, 5'b00001, 5'b00100, 5'b00001};
`endif
        p2 = 0;
        for (int k = 0; k < 4; k++) begin
            d = rnd_data();
            d[2*DW +: DW] = {(p2 >= 2), 15'(16'h0200 + 16'(p2))};
            cyc(5'b11010, 1, d, lk_exp[k], 5, 0, "pkt");
            if (lk_exp[k] == 5'b00100) p2++;
        end

        cyc('1, 0, rnd_data(), '0, 5, 0, "drain");
        cyc('1, 0, rnd_data(), '0, 5, 0, "drain");
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Round-robin arbiter that shares one router output port among N input buffers.
- Pops one flit per cycle from the winning buffer's RAM and registers it onto the output link.
- Tracks downstream free space with a credit counter. It never sends a flit without a credit.
- Sits between the per-port input buffers and the link register/crossbar output in each NoC router.

Parameters:
- N_PORTS, 5, number of requesting input buffers (N, S, E, W, Local).
- DATA_WIDTH, 16, flit width. Bit DATA_WIDTH-1 is the tail marker.
- CREDITS, 5, downstream buffer depth. Reset value of the credit counter.
- CNT_WIDTH, 3, credit counter width. Must hold CREDITS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- buf_empty_i  in  N_PORTS  per-buffer empty flag. 0 means a request.
- buf_data_i  in  N_PORTS*DATA_WIDTH  head flit of each buffer. Port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- buf_read_o  out  N_PORTS  one-hot combinational pop strobe to the granted buffer.
- out_data_o  out  DATA_WIDTH  registered flit to the downstream link.
- out_valid_o  out  1  registered. High for one cycle per flit sent.
- credit_i  in  1  single-cycle pulse. Downstream freed one slot.
- credit_cnt_o  out  CNT_WIDTH  current credit count.
- grant_o  out  N_PORTS  registered one-hot of the last granted port.
- credit_err_o  out  1  sticky. Set on credit overflow.

Behaviour:
- Reset values, applied immediately on reset low:
  - out_data_o=0, out_valid_o=0, grant_o=0, credit_err_o=0.
  - credit_cnt=CREDITS.
  - rr_ptr=0, lock=0.
  - buf_read_o=0 while reset is low.
- Request vector: req[i] = ~buf_empty_i[i].
- Arbitration is combinational from registered state:
  - Search req starting at rr_ptr, ascending, wrapping modulo N_PORTS.
  - The first set bit is the winner g.
  - Issue requires (|req) and credit_cnt>0.
- On issue in cycle t:
  - buf_read_o[g]=1 during cycle t.
  - At the end-of-t edge: out_data_o <= buf_data_i[g], out_valid_o <= 1, grant_o <= one-hot(g), rr_ptr <= (g+1) mod N_PORTS.
  - Latency from request visible to out_valid_o is 1 cycle.
  - Back-to-back issue every cycle is permitted.
- No issue (no request or credit_cnt=0):
  - buf_read_o=0.
  - out_valid_o <= 0.
  - out_data_o, grant_o and rr_ptr hold.
- Credit counter, per cycle:
  - Issue only: decrement.
  - credit_i only: increment.
  - Both: unchanged.
  - Neither: unchanged.
- Boundary conditions:
  - credit_cnt=0: no pop even with requests; requests wait. A credit_i arriving in that cycle allows issue from the next cycle. The counter never goes negative.
  - credit_i with credit_cnt=CREDITS and no issue: count stays at CREDITS and credit_err_o sets. It clears only on reset.
  - Single requester: it is granted every cycle while credits last; rr_ptr follows it.
  - Wrap-around: grant to port N_PORTS-1 sets rr_ptr=0.
  - Reset mid-transfer: any in-flight out_valid_o is dropped and all state returns to reset values. The input buffers are reset by the same signal.
- Required invariants:
  - At most one bit of buf_read_o is set per cycle.
  - buf_read_o[i] is never set while buf_empty_i[i]=1.

Optional Feature:
- Macro: OUTPUT_ARB_PACKET_LOCK_EN.
- Defined (wormhole packet lock):
  - A grant whose flit has bit DATA_WIDTH-1 = 0 sets lock=1 and records lock_port=g.
  - While lock=1, only lock_port may issue. Other requests are masked, and rr_ptr does not advance.
  - If lock_port is empty or credits are 0, nothing issues and the port stalls.
  - Issuing a flit with the tail bit set clears lock and sets rr_ptr=(lock_port+1) mod N_PORTS.
  - Reset clears lock.
- Not defined:
  - Per-flit round-robin as above. Tail bit is ignored; lock logic is absent.

Test Plan:
- Reset release, all buf_empty_i=5'b11111 -> buf_read_o=0, out_valid_o=0, credit_cnt_o=5, for 10 cycles.
- Ports 1 and 3 non-empty continuously, credit_i pulsed every cycle -> grants alternate 1,3,1,3. out_data_o equals the respective buf_data_i one cycle after each buf_read_o.
- Port 0 only requesting, no credit_i -> exactly 5 pops on consecutive cycles. credit_cnt_o goes 5→0, then buf_read_o=0. One credit_i pulse -> exactly one more pop on the following cycle.
- Issue and credit_i in the same cycle at credit_cnt=2 -> count stays 2. credit_i at count 5 with no issue -> count 5, credit_err_o=1 and stays 1.
- Port 4 granted (rr_ptr wraps) with ports 0 and 4 requesting -> next grant is port 0. Assert reset mid-stream -> out_valid_o=0 immediately, credit_cnt_o=5.
- With OUTPUT_ARB_PACKET_LOCK_EN: port 2 sends flits with tail bits 0,0,1 while port 0 requests -> three consecutive port-2 grants, then port 0. Without the macro the same stimulus interleaves 2,0,2.
